fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS core, wrapped around the existing PC register.
- Consumes the registered PC and drives that register's next-value input, so the PC holds during a stall and advances by 4 or redirects otherwise.
- Issues one instruction-memory request at a time and writes the returned word into the IF/ID pipeline register.
- Provides a 1-entry skid buffer, stall handling, redirect/flush, and a misaligned-fetch trap.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on pc_next while reset is high.
- NOP_INSTR, 32'h0000_0000, word loaded into IF/ID on flush or fault.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  32  current PC, the PC register output.
- pc_next  out  32  next PC, the PC register input (combinational).
- stall  in  1  decode cannot accept; IF/ID must hold.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_target  in  32  new PC when redirect=1.
- imem_req  out  1  request valid.
- imem_addr  out  32  request word address (= pc_in).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid (≥1 cycle after gnt).
- imem_rdata  in  32  instruction word.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_instr  out  32  fetched instruction.
- ifid_pc  out  32  PC of ifid_instr.
- ifid_pc4  out  32  ifid_pc + 4, mod 2^32.
- ifid_fault  out  1  IF/ID entry is a misaligned-fetch trap.

Behaviour:
- **Reset** (synchronous, active-high):
  - pc_next = RESET_PC, state = REQ.
  - ifid_valid = 0, ifid_fault = 0, ifid_instr = NOP_INSTR, ifid_pc = ifid_pc4 = 0.
  - Skid buffer is emptied and the drop flag cleared; imem_req = 0.
  - Reset must be held ≥2 cycles so pc_in = RESET_PC on exit.
  - Reset mid-operation abandons any outstanding request; a late rvalid in REQ is ignored.
- **Default:** pc_next = pc_in (hold). pc_in+4 or redirect_target is driven only as listed below.
- **IF/ID update:** loads when (!ifid_valid || !stall). Otherwise it holds.
- **State REQ:**
  - imem_req = 1 iff pc_in[1:0]==0 and !redirect.
  - On gnt go to WAIT.
  - If pc_in[1:0]!=0, issue no request. When IF/ID can load, write NOP_INSTR with ifid_fault=1, ifid_pc=pc_in, then go to ERR.
- **State WAIT:**
  - On rvalid with drop set: discard the word, clear drop, go to REQ.
  - On rvalid with IF/ID able to load: load imem_rdata and pc_in, set pc_next = pc_in+4, go to REQ.
  - On rvalid with IF/ID held: capture the word into the skid buffer, go to HOLD.
- **State HOLD:** when IF/ID can load, move the buffer into IF/ID, set pc_next = pc_in+4, go to REQ.
- **State ERR:** no requests, pc_next = pc_in; leave only on redirect.
- **Redirect** (highest priority after reset, any state):
  - pc_next = redirect_target.
  - Next cycle ifid_valid = 0, ifid_fault = 0; this overrides stall.
  - Skid buffer discarded.
  - In WAIT: set drop and stay until rvalid; if rvalid is in the same cycle, discard it and go to REQ.
  - In REQ/HOLD/ERR: go to REQ.
- **Simultaneous gnt and rvalid** in the same cycle is illegal (memory contract).
- **Throughput:** at most one outstanding request. Best case is 1 instruction per 2 cycles (gnt cycle + rvalid cycle).
- **Arithmetic:** PC+4 wraps modulo 2^32, so 32'hFFFF_FFFC → 0.

Decomposition:
- Shared package holds the state enum (REQ, WAIT, HOLD, ERR), the width constant XLEN=32, and NOP_INSTR.
- One sub-module, fetch_skid_buf: 1-entry {instr, pc} buffer with load/clear/valid.

Test Plan:
1. Reset 2 cycles, memory grants immediately and rvalid 1 cycle later returning 32'h2008_0005 → pc_next sequence 0→4→8; ifid_pc=0 and ifid_instr=32'h2008_0005; ifid_pc4=4.
2. Stall held 3 cycles while a word at PC 4 returns → word enters skid buffer, pc_in stays 4; after stall drops, IF/ID shows pc 4 and pc_in becomes 8 on the next edge.
3. Redirect to 32'h0040_0100 while in WAIT at PC 8 → late rvalid is discarded; ifid_valid=0 the next cycle; the next request has imem_addr = 32'h0040_0100.
4. Redirect to 32'h0000_0102 → no imem_req; ifid_fault=1 with ifid_pc=32'h0000_0102; pc holds until a redirect to 32'h0000_0200 resumes fetch.
5. pc_in=32'hFFFF_FFFC fetch completes → pc_next=0, ifid_pc4=0.
6. Reset asserted in WAIT with rvalid arriving the cycle after reset deasserts → word ignored, pc_next=RESET_PC, ifid_valid=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    // Word placed in IF/ID when an entry is flushed or carries a fetch trap.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // REQ: issue/hold a request, WAIT: one request outstanding,
    // HOLD: returned word parked in the skid buffer, ERR: misaligned PC trapped.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer that parks a returned word while IF/ID is stalled.
module fetch_skid_buf
    import fetch_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;

    // Capture on load; clear empties the entry (clear wins over load).
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC register input, talks to instruction
// memory with one outstanding request, and fills the IF/ID pipeline register.
//
// Memory handshake: imem_req is held with a stable imem_addr until a cycle with
// imem_gnt; the request is then accepted and exactly one imem_rvalid follows at
// least one cycle later. imem_gnt and imem_rvalid never coincide.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_next,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4,
    output logic            ifid_fault,
    output logic [1:0]      dbg_state
);

    fetch_state_e    state_q, state_d;
    logic            drop_q, drop_d;

    logic            ifid_valid_q, ifid_fault_q;
    logic [XLEN-1:0] ifid_instr_q, ifid_pc_q, ifid_pc4_q;

    logic            can_load;
    logic            ifid_load, ifid_flush;
    logic [XLEN-1:0] load_instr, load_pc;
    logic            load_fault;

    logic            skid_load, skid_clear, skid_valid;
    logic [XLEN-1:0] skid_instr, skid_pc;

    // IF/ID behaves as a pipeline register: it takes a new entry (or a bubble)
    // whenever decode is not holding a live instruction.
    assign can_load = !ifid_valid_q || !stall;

    fetch_skid_buf u_skid (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (imem_rdata),
        .pc_i    (pc_in),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    // State and drop-flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQ;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // Next state, PC selection, memory request and IF/ID/skid controls.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        pc_next    = pc_in;
        imem_req   = 1'b0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        load_instr = NOP_INSTR;
        load_pc    = pc_in;
        load_fault = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        if (reset) begin
            pc_next = RESET_PC;
            state_d = REQ;
            drop_d  = 1'b0;
        end else if (redirect) begin
            pc_next    = redirect_target;
            ifid_flush = 1'b1;
            skid_clear = 1'b1;
            // An accepted request cannot be cancelled: remember to drop its word.
            if (state_q == WAIT && !imem_rvalid) begin
                state_d = WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = REQ;
                drop_d  = 1'b0;
            end
        end else begin
            case (state_q)
                REQ: begin
                    if (pc_in[1:0] == 2'b00) begin
                        imem_req = 1'b1;
                        if (imem_gnt) state_d = WAIT;
                    end else if (can_load) begin
                        ifid_load  = 1'b1;
                        load_fault = 1'b1;
                        state_d    = ERR;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else if (can_load) begin
                            ifid_load  = 1'b1;
                            load_instr = imem_rdata;
                            pc_next    = pc_in + 32'd4;
                            state_d    = REQ;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (can_load && skid_valid) begin
                        ifid_load  = 1'b1;
                        load_instr = skid_instr;
                        load_pc    = skid_pc;
                        skid_clear = 1'b1;
                        pc_next    = pc_in + 32'd4;
                        state_d    = REQ;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: state_d = REQ;
            endcase
        end
    end

    // IF/ID register: flush beats stall; otherwise load an entry or a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid_q <= 1'b0;
            ifid_fault_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
        end else if (ifid_flush) begin
            ifid_valid_q <= 1'b0;
            ifid_fault_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
        end else if (can_load) begin
            if (ifid_load) begin
                ifid_valid_q <= 1'b1;
                ifid_fault_q <= load_fault;
                ifid_instr_q <= load_instr;
                ifid_pc_q    <= load_pc;
                ifid_pc4_q   <= load_pc + 32'd4;
            end else begin
                ifid_valid_q <= 1'b0;
                ifid_fault_q <= 1'b0;
            end
        end
    end

    assign imem_addr  = pc_in;
    assign ifid_valid = ifid_valid_q;
    assign ifid_fault = ifid_fault_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: random stall/redirect/reset traffic against a
// random-latency memory, with an instruction-stream scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam int          NCYC       = 3000;
  localparam int          PHASE0     = 45;
  localparam int          STREAM_LEN = 64;
  localparam int          W          = 97;

  // ---------------- clock / DUT ----------------
  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_gnt, imem_rvalid;
  logic [31:0] pc_in, pc_next, redirect_target, imem_addr, imem_rdata;
  logic        imem_req, ifid_valid, ifid_fault;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  // The PC register the fetch unit wraps.
  always @(posedge clk) pc_in <= pc_next;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_next(pc_next),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc4(ifid_pc4), .ifid_fault(ifid_fault), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  // Memory contents: word at address 0 is 32'h2008_0005, all others distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2008_0005;
  endfunction

  // Entry = {pc, instr, pc4, fault}. A stream started at t is t, t+4, ... for an
  // aligned t, or a single trap entry for a misaligned t.
  logic [W-1:0] exp_q[$];

  task automatic start_stream(input logic [31:0] t);
    logic [31:0] a;
    exp_q.delete();
    if (t[1:0] != 2'b00) begin
      exp_q.push_back({t, NOP, t + 32'd4, 1'b1});
    end else begin
      for (int i = 0; i < STREAM_LEN; i++) begin
        a = t + (32'(i) << 2);
        exp_q.push_back({a, mem_word(a), a + 32'd4, 1'b0});
      end
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return 32'h0040_0100;
      1: return 32'h0000_0102;
      2: return 32'h0000_0200;
      3: return 32'hFFFF_FFF4;
      4: return 32'h0000_0001;
      default: return r & 32'hFFFF_FFFC;
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int errors = 0;
  int checks = 0;
  int consumed = 0;
  int p0_consumed = 0;
  int mcyc = 0;
  logic rst_seen = 1'b0;
  logic prev_rst = 1'b0;
  logic prev_redirect = 1'b0;
  logic done = 1'b0;
  logic [W-1:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, mcyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("pc_next_reset", pc_next, RESET_PC);
      chk("req_in_reset", {31'b0, imem_req}, 32'd0);
      if (rst_seen) begin
        chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_ifid_fault", {31'b0, ifid_fault}, 32'd0);
        chk("rst_ifid_instr", ifid_instr, NOP);
        chk("rst_ifid_pc", ifid_pc, 32'd0);
        chk("rst_ifid_pc4", ifid_pc4, 32'd0);
      end
      rst_seen = 1'b1;
      start_stream(RESET_PC);
      prev_redirect = 1'b0;
    end else begin
      rst_seen = 1'b0;
      if (prev_rst) begin
        chk("post_rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("post_rst_pc_in", pc_in, RESET_PC);
      end
      if (prev_redirect) begin
        chk("flush_valid", {31'b0, ifid_valid}, 32'd0);
        chk("flush_fault", {31'b0, ifid_fault}, 32'd0);
      end
      if (imem_req) begin
        chk("req_addr", imem_addr, pc_in);
        chk("req_aligned", {30'b0, pc_in[1:0]}, 32'd0);
      end
      if (redirect) begin
        chk("redirect_no_req", {31'b0, imem_req}, 32'd0);
        chk("redirect_pc_next", pc_next, redirect_target);
      end
      // Decode takes the IF/ID entry at this edge.
      if (ifid_valid && !stall) begin
        consumed++;
        if (mcyc < PHASE0) p0_consumed++;
        if (exp_q.size() == 0) begin
          chk("unexpected_entry_pc", ifid_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("ifid_pc", ifid_pc, e[96:65]);
          chk("ifid_instr", ifid_instr, e[64:33]);
          chk("ifid_pc4", ifid_pc4, e[32:1]);
          chk("ifid_fault", {31'b0, ifid_fault}, {31'b0, e[0]});
        end
      end
      if (redirect) start_stream(redirect_target);
      prev_redirect = redirect;
    end
    prev_rst = reset;

    // Best case: one instruction per two cycles once reset is released.
    if (mcyc == PHASE0) chk("phase0_throughput", 32'(p0_consumed), 32'd20);

    if (done) begin
      chk("overall_progress", 32'(consumed >= 300), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
    mcyc++;
  end

  // ---------------- driver + memory model ----------------
  logic        out_v = 1'b0;
  logic [31:0] out_addr = '0;
  int          out_cnt = 0;
  int          rst_cnt = 3;
  int          gap = 10;
  logic        want_rst = 1'b0;
  logic        phase0;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      phase0 = (cyc < PHASE0);
      imem_gnt = 1'b0;
      redirect = 1'b0;
      stall = 1'b0;
      if (rst_cnt > 0) begin
        reset = 1'b1;
        rst_cnt--;
      end else begin
        reset = 1'b0;
      end

      // Memory return path.
      imem_rvalid = 1'b0;
      if (out_v) begin
        if (out_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_word(out_addr);
          out_v = 1'b0;
        end else begin
          out_cnt--;
        end
      end else begin
        imem_rdata = $urandom;
      end

      if (!reset && !phase0) begin
        stall = ($urandom_range(0, 99) < 30);
        if (gap == 0) begin
          redirect = 1'b1;
          redirect_target = pick_target();
          gap = $urandom_range(8, 50);
        end else begin
          gap--;
        end
        if (rst_cnt == 0 && $urandom_range(0, 399) == 0) rst_cnt = $urandom_range(2, 3);
        if (cyc == 700 || cyc == 1600 || cyc == 2400) want_rst = 1'b1;
        // Reset while a request is outstanding, word returning just after reset.
        if (want_rst && rst_cnt == 0 && out_v && dbg_state == 2'd1) begin
          want_rst = 1'b0;
          rst_cnt = 2;
          out_cnt = 2;
        end
      end

      #1;
      // Grant path: one outstanding request, never alongside rvalid.
      if (imem_req && !out_v && !imem_rvalid &&
          (phase0 || $urandom_range(0, 99) < 60)) begin
        imem_gnt = 1'b1;
        out_v = 1'b1;
        out_addr = imem_addr;
        out_cnt = phase0 ? 0 : $urandom_range(0, 3);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0; stall = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    done = 1'b1;
  end

endmodule
